// File: rtl/exec_stage_pkg.sv
// Shared definitions for the execute stage: widths, funct7 codes, FSM states
// and the latched-instruction payload.
package exec_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned F7_W   = 7;

  localparam logic [F7_W-1:0] FUNCT7_M   = 7'b0000001;
  localparam logic [F7_W-1:0] FUNCT7_SUB = 7'b0100000;
  localparam logic [F7_W-1:0] FUNCT7_SRA = 7'b0100000;

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, OUT} exec_state_t;

  // Instruction fields held for the ALU while it executes
  typedef struct packed {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              is_imm;
    logic [F3_W-1:0]   funct3;
    logic [F7_W-1:0]   funct7;
    logic [REG_W-1:0]  rd;
    logic              is_div;
  } exec_req_t;

  // Division/remainder ops are the only multi-cycle ALU operations
  function automatic logic is_div_op(input logic is_imm,
                                     input logic [F3_W-1:0] funct3,
                                     input logic [F7_W-1:0] funct7);
    return !is_imm && (funct7 == FUNCT7_M) && funct3[2];
  endfunction

endpackage

// File: rtl/exec_stage.sv
// Execute-stage controller: accepts one decoded instruction, drives the
// external ALU (start pulse + divide wait) and returns the result.
// Optional forwarding port set enabled by defining EXEC_FWD_EN.
module exec_stage
  import exec_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_rs1,
  input  logic [DATA_W-1:0] in_rs2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_is_imm,
  input  logic [F3_W-1:0]   in_funct3,
  input  logic [F7_W-1:0]   in_funct7,
  input  logic [REG_W-1:0]  in_rd,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic              alu_is_imm,
  output logic [F3_W-1:0]   alu_funct3,
  output logic [F7_W-1:0]   alu_funct7,
  output logic              alu_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef EXEC_FWD_EN
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic [REG_W-1:0]  out_rd
);

  exec_state_t       state, state_d;
  exec_req_t         req_q, req_d;
  logic              alu_ready_d;
  logic              out_valid_d;
  logic [DATA_W-1:0] out_data_d;
  logic [REG_W-1:0]  out_rd_d;
  logic              accept;
  logic              capture;

  // Accept is combinational on out_ready so OUT can hand off and refill in one cycle
  assign in_ready = (state == IDLE) || ((state == OUT) && out_ready);

  // ALU fields come straight from the request register; it is zero outside EXEC/WAIT
  assign alu_in1    = req_q.op1;
  assign alu_in2    = req_q.op2;
  assign alu_is_imm = req_q.is_imm;
  assign alu_funct3 = req_q.funct3;
  assign alu_funct7 = req_q.funct7;

  // Next-state, request latch and result capture
  always_comb begin
    state_d     = state;
    req_d       = req_q;
    alu_ready_d = 1'b0;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_rd_d    = out_rd;
    accept      = 1'b0;
    capture     = 1'b0;

    unique case (state)
      IDLE: accept = in_valid;
      // alu_done is ignored here: the divider flags done before it goes busy
      EXEC: begin
        if (req_q.is_div) state_d = WAIT;
        else              capture = 1'b1;
      end
      WAIT: capture = alu_done;
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) accept  = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      state_d     = OUT;
      out_valid_d = 1'b1;
      out_data_d  = alu_out;
      out_rd_d    = req_q.rd;
      req_d       = '0;
    end

    if (accept) begin
      state_d      = EXEC;
      alu_ready_d  = 1'b1;
      req_d.op1    = in_rs1;
      req_d.op2    = in_is_imm ? in_imm : in_rs2;
      req_d.is_imm = in_is_imm;
      req_d.funct3 = in_funct3;
      req_d.funct7 = in_funct7;
      req_d.rd     = in_rd;
      req_d.is_div = is_div_op(in_is_imm, in_funct3, in_funct7);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_q     <= '0;
      alu_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rd    <= '0;
    end else begin
      state     <= state_d;
      req_q     <= req_d;
      alu_ready <= alu_ready_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_rd    <= out_rd_d;
    end
  end

`ifdef EXEC_FWD_EN
  // Forward a pending nonzero-destination result to earlier stages
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fwd_valid <= 1'b0;
    else      fwd_valid <= (state_d == OUT) && (out_rd_d != '0);
  end

  assign fwd_rd   = out_rd;
  assign fwd_data = out_data;
`endif

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: behavioural ALU stub with a 32-cycle
// divider, a transaction-level reference model, directed cases and random traffic.
module tb_exec_stage;
  import exec_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_rs1 = '0, in_rs2 = '0, in_imm = '0;
  logic        in_is_imm = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] alu_in1, alu_in2;
  logic        alu_is_imm;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic        alu_ready;
  logic [31:0] alu_out;
  logic        alu_done;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
`ifdef EXEC_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  exec_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_is_imm(in_is_imm),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_is_imm(alu_is_imm),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .alu_ready(alu_ready),
    .alu_out(alu_out), .alu_done(alu_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef EXEC_FWD_EN
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
    .out_rd(out_rd)
  );

  // RV32 ALU semantics (including M-extension) used by the stub and the model
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic imm, input logic [2:0] f3,
                                         input logic [6:0] f7);
    logic [31:0] r;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (!imm && f7 == FUNCT7_M) begin
      case (f3)
        3'd4:    r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
        3'd5:    r = (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6:    r = (b == 0) ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
        3'd7:    r = (b == 0) ? a : a % b;
        default: r = 32'(a * b);
      endcase
    end else begin
      case (f3)
        3'd0:    r = (!imm && f7 == FUNCT7_SUB) ? a - b : a + b;
        3'd1:    r = a << b[4:0];
        3'd2:    r = {31'd0, $signed(a) < $signed(b)};
        3'd3:    r = {31'd0, a < b};
        3'd4:    r = a ^ b;
        3'd5:    r = (f7 == FUNCT7_SRA) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6:    r = a | b;
        default: r = a & b;
      endcase
    end
    return r;
  endfunction

  // ALU stub: combinational result, divider counts 31..0 after a start pulse
  logic       alu_busy = 1'b0;
  logic [4:0] alu_cnt  = '0;
  logic       stub_div;
  assign stub_div = !alu_is_imm && (alu_funct7 == FUNCT7_M) && alu_funct3[2];
  assign alu_out  = alu_fn(alu_in1, alu_in2, alu_is_imm, alu_funct3, alu_funct7);
  assign alu_done = alu_busy ? (alu_cnt == 5'd0) : 1'b1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_busy <= 1'b0;
      alu_cnt  <= '0;
    end else if (alu_ready && stub_div) begin
      alu_busy <= 1'b1;
      alu_cnt  <= 5'd31;
    end else if (alu_busy) begin
      if (alu_cnt == 5'd0) alu_busy <= 1'b0;
      else                 alu_cnt  <= alu_cnt - 5'd1;
    end
  end

  // Reference model: one transaction in flight, fixed latency 2 or 34 from accept
  bit          m_infl = 0, m_outv = 0, m_div = 0, m_imm = 0, m_acc = 0;
  int          m_age = 0;
  logic [31:0] m_op1 = '0, m_op2 = '0, m_res = '0, m_data = '0;
  logic [2:0]  m_f3 = '0;
  logic [6:0]  m_f7 = '0;
  logic [4:0]  m_rd = '0, m_out_rd = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_infl = 0; m_outv = 0; m_div = 0; m_imm = 0; m_age = 0;
      m_op1 = '0; m_op2 = '0; m_f3 = '0; m_f7 = '0; m_rd = '0;
      m_data = '0; m_out_rd = '0;
    end else begin
      m_acc = in_valid && (!m_infl || (m_outv && out_ready));
      if (m_infl && m_outv && out_ready) begin
        m_outv = 0;
        m_infl = 0;
      end else if (m_infl && !m_outv) begin
        m_age++;
        if (m_age == (m_div ? 34 : 2)) begin
          m_outv   = 1;
          m_data   = m_res;
          m_out_rd = m_rd;
        end
      end
      if (m_acc) begin
        m_infl = 1;
        m_age  = 1;
        m_op1  = in_rs1;
        m_op2  = in_is_imm ? in_imm : in_rs2;
        m_imm  = in_is_imm;
        m_f3   = in_funct3;
        m_f7   = in_funct7;
        m_rd   = in_rd;
        m_div  = !in_is_imm && (in_funct7 == 7'd1) && in_funct3[2];
        m_res  = alu_fn(m_op1, m_op2, m_imm, m_f3, m_f7);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    bit alu_act;
    alu_act = m_infl && !m_outv;
    chk("in_ready",   32'(in_ready),   32'(!m_infl || (m_outv && out_ready)));
    chk("out_valid",  32'(out_valid),  32'(m_outv));
    chk("out_data",   out_data,        m_data);
    chk("out_rd",     32'(out_rd),     32'(m_out_rd));
    chk("alu_ready",  32'(alu_ready),  32'(alu_act && m_age == 1));
    chk("alu_in1",    alu_in1,         alu_act ? m_op1 : 32'd0);
    chk("alu_in2",    alu_in2,         alu_act ? m_op2 : 32'd0);
    chk("alu_is_imm", 32'(alu_is_imm), 32'(alu_act && m_imm));
    chk("alu_funct3", 32'(alu_funct3), alu_act ? 32'(m_f3) : 32'd0);
    chk("alu_funct7", 32'(alu_funct7), alu_act ? 32'(m_f7) : 32'd0);
`ifdef EXEC_FWD_EN
    chk("fwd_valid",  32'(fwd_valid),  32'(m_outv && m_out_rd != 5'd0));
    chk("fwd_data",   fwd_data,        m_data);
    chk("fwd_rd",     32'(fwd_rd),     32'(m_out_rd));
`endif
  end

  task automatic drive(input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic is_imm, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd);
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_is_imm = is_imm;
    in_funct3 = f3; in_funct7 = f7; in_rd = rd;
  endtask

  // Offer an instruction and return just after the accepting edge
  task automatic issue(input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic is_imm, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd);
    bit ok, a;
    ok = 0;
    @(negedge clk); #1;
    drive(rs1, rs2, imm, is_imm, f3, f7, rd);
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a = in_ready;
      @(posedge clk); #1;
      if (a) begin ok = 1; break; end
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // Count cycles from accept until out_valid; note EXEC-cycle fields and start pulses
  task automatic wait_out(output int lat, output int pulses, output logic [31:0] in2_exec,
                          output logic imm_exec);
    lat = -1; pulses = 0; in2_exec = '0; imm_exec = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin in2_exec = alu_in2; imm_exec = alu_is_imm; end
      if (alu_ready) pulses++;
      if (out_valid) begin lat = k; break; end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, pulses;
    logic [31:0] in2e;
    logic        imme;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd0);
    #1 rst = 1'b1;

    // ADD 5+7
    issue(32'd5, 32'd7, 32'd0, 1'b0, 3'd0, 7'd0, 5'd3);
    wait_out(lat, pulses, in2e, imme);
    chk("add_lat", 32'(lat), 32'd2);
    chk("add_data", out_data, 32'd12);
    chk("add_rd", 32'(out_rd), 32'd3);

    // ADDI 1 + (-1)
    issue(32'd1, 32'd99, 32'hFFFF_FFFF, 1'b1, 3'd0, 7'd0, 5'd4);
    wait_out(lat, pulses, in2e, imme);
    chk("addi_data", out_data, 32'd0);
    chk("addi_alu_in2", in2e, 32'hFFFF_FFFF);
    chk("addi_alu_is_imm", 32'(imme), 32'd1);

    // DIVU and REMU 100/7
    issue(32'd100, 32'd7, 32'd0, 1'b0, 3'd5, 7'd1, 5'd5);
    wait_out(lat, pulses, in2e, imme);
    chk("divu_lat", 32'(lat), 32'd34);
    chk("divu_data", out_data, 32'd14);
    chk("divu_pulses", 32'(pulses), 32'd1);
    issue(32'd100, 32'd7, 32'd0, 1'b0, 3'd7, 7'd1, 5'd6);
    wait_out(lat, pulses, in2e, imme);
    chk("remu_lat", 32'(lat), 32'd34);
    chk("remu_data", out_data, 32'd2);
    chk("remu_pulses", 32'(pulses), 32'd1);

    // Backpressure on SUB 9-3
    @(negedge clk); #1 out_ready = 1'b0;
    issue(32'd9, 32'd3, 32'd0, 1'b0, 3'd0, 7'h20, 5'd7);
    wait_out(lat, pulses, in2e, imme);
    chk("sub_lat", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", out_data, 32'd6);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    #1 out_ready = 1'b1;

    // Back-to-back ADDs through the OUT->EXEC path
    issue_b2b();

    // Reset in the middle of a DIVU
    issue(32'd100, 32'd7, 32'd0, 1'b0, 3'd5, 7'd1, 5'd8);
    repeat (10) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    chk("midrst_alu_in1", alu_in1, 32'd0);
    chk("midrst_alu_funct7", 32'(alu_funct7), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    issue(32'd1, 32'd1, 32'd0, 1'b0, 3'd0, 7'd0, 5'd9);
    wait_out(lat, pulses, in2e, imme);
    chk("post_rst_lat", 32'(lat), 32'd2);
    chk("post_rst_data", out_data, 32'd2);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 9) < 7);
      in_rs1    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
      in_rs2    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
      in_imm    = $urandom;
      in_is_imm = ($urandom_range(0, 9) < 3);
      in_funct3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0: in_funct7 = 7'd0;
        1: in_funct7 = 7'h20;
        2: in_funct7 = 7'd1;
        default: in_funct7 = 7'($urandom);
      endcase
      in_rd = 5'($urandom);
    end
    @(negedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Two ADDs with in_valid/out_ready high: second accept coincides with first handshake
  task automatic issue_b2b();
    bit ok, a;
    ok = 0;
    @(negedge clk); #1;
    out_ready = 1'b1;
    drive(32'd3, 32'd4, 32'd0, 1'b0, 3'd0, 7'd0, 5'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a = in_ready;
      @(posedge clk); #1;
      if (a) begin ok = 1; break; end
    end
    if (!ok) chk("b2b_accept_timeout", 32'd0, 32'd1);
    drive(32'd10, 32'd20, 32'd0, 1'b0, 3'd0, 7'd0, 5'd2);
    @(negedge clk);
    chk("b2b_n1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("b2b_n2_valid", 32'(out_valid), 32'd1);
    chk("b2b_n2_data", out_data, 32'd7);
    chk("b2b_n2_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_n3_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("b2b_n4_valid", 32'(out_valid), 32'd1);
    chk("b2b_n4_data", out_data, 32'd30);
    chk("b2b_n4_rd", 32'(out_rd), 32'd2);
  endtask

endmodule
